// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and helpers for the receiver and the future transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int DEFAULT_DATA_BITS = 8;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous input, with a selectable reset level
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with mid-bit sampling and one-cycle valid/error strobes
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int IW  = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;

  generate
    if (CPB < 8) begin : g_bad_baud
      $error("uart_receiver: CLK_FREQ/BAUD must be at least 8");
    end
  endgenerate

  state_t               state, state_next;
  logic                 rx_s, rx_prev, tick, stop_ok, stop_bad;
  logic [CW-1:0]        baud_cnt, term;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;

  uart_sync #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (rx_prev && !rx_s) ? START : IDLE;
      START:   if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == IW'(DATA_BITS - 1)) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The start bit is sampled after half a bit so every later sample lands mid-bit
  always_comb begin
    term     = state == START ? CW'(CPB / 2 - 1) : CW'(CPB - 1);
    tick     = state != IDLE && baud_cnt == term;
    stop_ok  = tick && state == STOP && rx_s;
    stop_bad = tick && state == STOP && !rx_s;
    rx_busy  = state != IDLE;
  end

  always_ff @(posedge clk)
    if (rst) begin
      rx_prev      <= UART_IDLE_LEVEL;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_prev      <= rx_s;
      baud_cnt     <= (state == IDLE || tick || state_next != state) ? '0 : baud_cnt + 1'b1;
      bit_idx      <= state != DATA ? '0 : tick ? bit_idx + 1'b1 : bit_idx;
      if (tick && state == DATA) shift[bit_idx] <= rx_s;
      if (stop_ok) rx_data <= shift;
      rx_valid     <= stop_ok;
      rx_frame_err <= stop_bad;
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 10 clocks per bit, scoreboard of expected strobes with latency checks
module tb_uart_receiver;
  typedef struct {
    bit         err;
    logic [7:0] data;
    int         start;
  } evt_t;

  logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;
  int         compared = 0, mismatched = 0, cyc = 0, t_set = 0, busy_cycles = 0;
  evt_t       sb[$];
  evt_t       e_mon;
  logic [7:0] v;

  uart_receiver #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int val, input int lo, input int hi);
    compared++;
    assert (val >= lo && val <= hi) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Hold the line at level lv for n clock cycles, changing it just after a rising edge
  task automatic drive(input logic lv, input int n);
    @(posedge clk);
    #1;
    uart_rx = lv;
    t_set = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_n);
    drive(1'b0, 10);
    sb.push_back('{err: !stop, data: b, start: t_set});
    for (int i = 0; i < 8; i++) drive(b[i], 10);
    drive(stop, stop_n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rx_busy) busy_cycles++;
    if (!rst && (rx_valid || rx_frame_err)) begin
      if (sb.size() == 0) check("unexpected_pulse", 32'({rx_valid, rx_frame_err}), 32'd0);
      else begin
        e_mon = sb.pop_front();
        check("pulse_kind", 32'({rx_valid, rx_frame_err}), e_mon.err ? 32'd1 : 32'd2);
        if (!e_mon.err) check("rx_data", 32'(rx_data), 32'(e_mon.data));
        check_rng("latency", cyc - e_mon.start, 97, 99);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_err", 32'(rx_frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 20);

    busy_cycles = 0;
    send(8'hA5, 1'b1, 10);
    drive(1'b1, 20);
    wait_drain();
    check_rng("busy_a5", busy_cycles, 94, 97);

    send(8'h00, 1'b1, 10);
    send(8'hFF, 1'b1, 10);
    send(8'h55, 1'b1, 10);
    drive(1'b1, 20);
    wait_drain();

    send(8'h3C, 1'b0, 10);
    drive(1'b1, 20);
    wait_drain();
    check("held_after_err", 32'(rx_data), 32'h55);
    send(8'h81, 1'b1, 10);
    drive(1'b1, 20);
    wait_drain();

    busy_cycles = 0;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check_rng("glitch_busy", busy_cycles, 1, 6);
    check("glitch_idle", 32'(rx_busy), 32'd0);

    v = 8'h96;
    drive(1'b0, 10);
    for (int i = 0; i < 4; i++) drive(v[i], 10);
    drive(v[4], 5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_err", 32'(rx_frame_err), 32'd0);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    drive(1'b1, 30);
    check("midrst_quiet", 32'(sb.size()), 32'd0);
    send(8'h69, 1'b1, 10);
    drive(1'b1, 20);
    wait_drain();

    drive(1'b0, 1);
    sb.push_back('{err: 1'b1, data: 8'h00, start: t_set});
    repeat (299) @(posedge clk);
    @(negedge clk);
    check("break_idle", 32'(rx_busy), 32'd0);
    check("break_drained", 32'(sb.size()), 32'd0);
    check("break_data", 32'(rx_data), 32'h69);
    drive(1'b1, 20);
    check("break_recover_idle", 32'(rx_busy), 32'd0);
    send(8'h5A, 1'b1, 10);
    drive(1'b1, 20);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
